// File: rtl/uart_imem_loader.sv
// Boot loader: assembles UART bytes little-endian into 32-bit words, writes them to
// consecutive imem addresses and holds the CPU in reset until a terminator or full memory.
module uart_imem_loader #(
  parameter int          ADDR_W         = 8,
  parameter int          TIMEOUT_CYCLES = 104200,
  parameter logic [31:0] TERM_WORD      = 32'hFFFF_FFFF
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              load_en,
  input  logic              uart_rx_valid,
  input  logic [7:0]        uart_rx_data,
  input  logic              uart_rx_break,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_rstn,
  output logic              write_done,
  output logic [ADDR_W:0]   word_count
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam int                IDLE_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

  logic [1:0]        state_reg;
  logic              valid_prev_reg;
  logic [1:0]        byte_cnt_reg;
  logic [23:0]       word_buf_reg;
  logic [IDLE_W-1:0] idle_cnt_reg;
  logic              pend_reg;
  logic [31:0]       pend_word_reg;
  logic [ADDR_W-1:0] addr_reg;

  logic accept;
  logic timeout_hit;

  assign accept      = (state_reg == LOAD) && uart_rx_valid && !valid_prev_reg;
  assign timeout_hit = (byte_cnt_reg != 2'd0) && (idle_cnt_reg == IDLE_LAST);

  // A completed word is staged in pend_reg for one cycle; the terminator check and the
  // write strobe both happen on the following edge, so all outputs stay registered.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg      <= IDLE;
      valid_prev_reg <= 1'b0;
      byte_cnt_reg   <= 2'd0;
      word_buf_reg   <= '0;
      idle_cnt_reg   <= '0;
      pend_reg       <= 1'b0;
      pend_word_reg  <= '0;
      addr_reg       <= '0;
      imem_we        <= 1'b0;
      imem_addr      <= '0;
      imem_wdata     <= '0;
      cpu_rstn       <= 1'b0;
      write_done     <= 1'b0;
      word_count     <= '0;
    end else begin
      valid_prev_reg <= uart_rx_valid;
      imem_we        <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (load_en) begin
            state_reg    <= LOAD;
            addr_reg     <= '0;
            word_count   <= '0;
            byte_cnt_reg <= 2'd0;
            idle_cnt_reg <= '0;
            pend_reg     <= 1'b0;
          end
        end
        LOAD: begin
          if (!load_en) begin
            state_reg    <= IDLE;
            byte_cnt_reg <= 2'd0;
            idle_cnt_reg <= '0;
            pend_reg     <= 1'b0;
          end else begin
            if (pend_reg) begin
              pend_reg <= 1'b0;
              if (pend_word_reg == TERM_WORD) begin
                state_reg  <= DONE;
                cpu_rstn   <= 1'b1;
                write_done <= 1'b1;
              end else begin
                imem_we    <= 1'b1;
                imem_addr  <= addr_reg;
                imem_wdata <= pend_word_reg;
                addr_reg   <= addr_reg + 1'b1;
                word_count <= word_count + 1'b1;
                if (addr_reg == ADDR_LAST) begin
                  state_reg  <= DONE;
                  cpu_rstn   <= 1'b1;
                  write_done <= 1'b1;
                end
              end
            end
            // Break beats a coincident byte; a coincident timeout restarts the word with it.
            if (uart_rx_break) begin
              byte_cnt_reg <= 2'd0;
              idle_cnt_reg <= '0;
            end else if (accept) begin
              idle_cnt_reg <= '0;
              if (timeout_hit) begin
                word_buf_reg[7:0] <= uart_rx_data;
                byte_cnt_reg      <= 2'd1;
              end else begin
                case (byte_cnt_reg)
                  2'd0: word_buf_reg[7:0]   <= uart_rx_data;
                  2'd1: word_buf_reg[15:8]  <= uart_rx_data;
                  2'd2: word_buf_reg[23:16] <= uart_rx_data;
                  default: begin
                    pend_reg      <= 1'b1;
                    pend_word_reg <= {uart_rx_data, word_buf_reg};
                  end
                endcase
                byte_cnt_reg <= byte_cnt_reg + 2'd1;
              end
            end else if (byte_cnt_reg != 2'd0) begin
              if (timeout_hit) begin
                byte_cnt_reg <= 2'd0;
                idle_cnt_reg <= '0;
              end else begin
                idle_cnt_reg <= idle_cnt_reg + 1'b1;
              end
            end
          end
        end
        DONE: begin
          state_reg <= DONE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule
